// File: rtl/guess_pkg.sv
// Shared constants, FSM encoding and secret reduction for the guess-the-number game.
package guess_pkg;

    localparam int unsigned RANGE_MAX = 100;

    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_9  = 8'h39;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_L  = 8'h4C;
    localparam logic [7:0] CHR_H  = 8'h48;
    localparam logic [7:0] CHR_C  = 8'h43;
    localparam logic [7:0] CHR_E  = 8'h45;
    localparam logic [7:0] CHR_X  = 8'h58;

    typedef enum logic [1:0] {
        StParse,
        StCheck,
        StSend,
        StOver
    } state_e;

    // Fold the low 7 LFSR bits into 0..99; 100..127 map onto 72..99.
    function automatic logic [6:0] reduce_secret(input logic [7:0] v);
        if (v[6:0] < 7'(RANGE_MAX)) begin
            return v[6:0];
        end
        return v[6:0] - 7'(128 - RANGE_MAX);
    endfunction

endpackage

// File: rtl/guess_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with its value reduced to 0..99.
module guess_lfsr
    import guess_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] rand_val
);

    logic [7:0] lfsr;

    // Shift every cycle; feedback is the XOR of taps 8, 6, 5, 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign rand_val = reduce_secret(lfsr);

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-the-number sequencer: parses ASCII guesses from the UART receiver, compares them with
// a latched secret and streams a three-byte verdict to the UART transmitter.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned MAX_TRIES  = 7,
    parameter int unsigned MAX_DIGITS = 3,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       new_game,
    output logic [3:0] tries_left,
    output logic       game_over,
    output logic       win,
    output logic [6:0] secret
);

    localparam logic [3:0] MaxTries  = 4'(MAX_TRIES);
    localparam logic [3:0] MaxDigits = 4'(MAX_DIGITS);

    state_e      state;
    logic [9:0]  acc;
    logic [3:0]  count;
    logic        err;
    logic        pend;
    logic        game_end;
    logic [1:0]  byte_idx;
    logic [6:0]  rand_val;

    logic        is_digit;
    logic        is_term;
    logic [13:0] acc_mul;
    logic [9:0]  acc_sat;
    logic [3:0]  count_inc;
    logic [3:0]  tries_dec;
    logic        apply;

    guess_lfsr #(
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .rand_val(rand_val)
    );

    // Parser arithmetic and the new-game apply condition (a live pulse counts as pending).
    always_comb begin
        is_digit  = (rx_data >= CHR_0) && (rx_data <= CHR_9);
        is_term   = (rx_data == CHR_CR) || (rx_data == CHR_LF);
        acc_mul   = 14'(acc) * 14'd10 + 14'(rx_data[3:0]);
        acc_sat   = (acc_mul > 14'd1023) ? 10'd1023 : acc_mul[9:0];
        count_inc = (count == 4'hF) ? count : count + 4'd1;
        tries_dec = tries_left - 4'd1;
        apply     = (pend || new_game) && ((state == StParse) || (state == StOver));
    end

    // Game FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StParse;
            acc        <= '0;
            count      <= '0;
            err        <= 1'b0;
            pend       <= 1'b0;
            game_end   <= 1'b0;
            byte_idx   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tries_left <= MaxTries;
            game_over  <= 1'b0;
            win        <= 1'b0;
            secret     <= reduce_secret(LFSR_SEED);
        end else begin
            pend <= pend | new_game;
            if (apply) begin
                // Any byte arriving with the apply is dropped along with the old parser state.
                pend       <= 1'b0;
                secret     <= rand_val;
                tries_left <= MaxTries;
                game_over  <= 1'b0;
                win        <= 1'b0;
                game_end   <= 1'b0;
                acc        <= '0;
                count      <= '0;
                err        <= 1'b0;
                state      <= StParse;
            end else begin
                unique case (state)
                    StParse: begin
                        if (rx_valid) begin
                            if (is_digit) begin
                                acc   <= acc_sat;
                                count <= count_inc;
                                if (count_inc > MaxDigits) begin
                                    err <= 1'b1;
                                end
                            end else if (is_term) begin
                                // Empty lines are ignored so CR LF yields a single guess.
                                if (count != 4'd0) begin
                                    state <= StCheck;
                                end
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    StCheck: begin
                        tx_valid <= 1'b1;
                        byte_idx <= 2'd0;
                        state    <= StSend;
                        acc      <= '0;
                        count    <= '0;
                        err      <= 1'b0;
                        if (err || (acc >= 10'(RANGE_MAX))) begin
                            tx_data <= CHR_E;
                        end else if (acc == 10'(secret)) begin
                            tx_data  <= CHR_C;
                            win      <= 1'b1;
                            game_end <= 1'b1;
                        end else begin
                            tries_left <= tries_dec;
                            if (tries_dec == 4'd0) begin
                                tx_data  <= CHR_X;
                                win      <= 1'b0;
                                game_end <= 1'b1;
                            end else if (acc < 10'(secret)) begin
                                tx_data <= CHR_L;
                            end else begin
                                tx_data <= CHR_H;
                            end
                        end
                    end
                    StSend: begin
                        if (tx_ready) begin
                            case (byte_idx)
                                2'd0: begin
                                    tx_data  <= CHR_CR;
                                    byte_idx <= 2'd1;
                                end
                                2'd1: begin
                                    tx_data  <= CHR_LF;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    tx_data   <= '0;
                                    tx_valid  <= 1'b0;
                                    game_over <= game_end;
                                    state     <= game_end ? StOver : StParse;
                                end
                            endcase
                        end
                    end
                    StOver: begin
                        // Wait for a new game; received bytes are dropped.
                    end
                    default: state <= StParse;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl against a line-level model of the game rules.
module tb_guess_game_ctrl;

    localparam int MaxTries  = 7;
    localparam int MaxDigits = 3;
    localparam logic [7:0] Seed = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       new_game = 1'b0;
    logic [3:0] tries_left;
    logic       game_over;
    logic       win;
    logic [6:0] secret;

    int n_checks = 0;
    int n_errors = 0;

    // Reference game state
    logic [7:0] m_lfsr;
    int         m_secret;
    int         m_tries;
    bit         m_over;
    bit         m_win;

    always #5 clk = ~clk;

    guess_game_ctrl #(
        .MAX_TRIES (MaxTries),
        .MAX_DIGITS(MaxDigits),
        .LFSR_SEED (Seed)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .new_game  (new_game),
        .tries_left(tries_left),
        .game_over (game_over),
        .win       (win),
        .secret    (secret)
    );

    // Reference LFSR: taps 8,6,5,4 as a parity mask over the register.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= Seed;
        else     m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    function automatic int ref_reduce(input logic [7:0] v);
        int x;
        x = int'(v) % 128;
        return (x >= 100) ? x - 28 : x;
    endfunction

    // Verdict for one guess line (without terminator); updates the reference game state.
    task automatic model_guess(input string s, output logic [7:0] v);
        int val = 0;
        int nd  = 0;
        bit bad = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] >= "0" && s[i] <= "9") begin
                nd++;
                if (val < 100000) val = val * 10 + int'(s[i] - "0");
            end else begin
                bad = 1;
            end
        end
        if (bad || nd > MaxDigits || val > 99) begin
            v = "E";
        end else if (val == m_secret) begin
            v = "C"; m_win = 1; m_over = 1;
        end else begin
            m_tries--;
            if (m_tries == 0) begin
                v = "X"; m_win = 0; m_over = 1;
            end else begin
                v = (val < m_secret) ? "L" : "H";
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // term: 0 = CR, 1 = LF, 2 = CR LF
    task automatic send_line(input string s, input int term, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        if (term == 1) send_byte(8'h0A);
        else send_byte(8'h0D);
        if (term == 2) send_byte(8'h0A);
    endtask

    // Capture three transmitted bytes (first byte ends in [23:16]).
    task automatic recv3(input bit rnd_ready, output logic [23:0] got, output bit timeout);
        int n = 0;
        got = '0;
        timeout = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid === 1'b1 && tx_ready) begin
                got = {got[15:0], tx_data};
                n++;
            end
            @(posedge clk); #1;
            if (n == 3) begin
                timeout = 0;
                break;
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            if (tx_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        m_secret = ref_reduce(m_lfsr);
        @(posedge clk); #1;
        new_game = 1'b0;
        m_tries = MaxTries; m_over = 0; m_win = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_secret = ref_reduce(Seed); m_tries = MaxTries; m_over = 0; m_win = 0;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_tx: got valid=%b data=%h want 0/00", tx_valid, tx_data);
        end
        n_checks++;
        if (tries_left !== 4'd7 || game_over !== 1'b0 || win !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: got tries=%0d over=%b win=%b want 7/0/0",
                     tries_left, game_over, win);
        end
        n_checks++;
        if (secret !== 7'd37) begin
            n_errors++;
            $display("FAIL reset_secret: got %0d want 37", secret);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        int          seen;
        model_guess("50", v);
        send_byte("5");
        send_byte("0");
        send_byte(8'h0D);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_check_cycle: got tx_valid=%b want 0", tx_valid);
        end
        send_byte(8'h0A);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== "H") begin
            n_errors++;
            $display("FAIL latency_first_byte: got valid=%b data=%h want 1/48", tx_valid, tx_data);
        end
        recv3(0, got, to);
        n_checks++;
        if (to || got !== {v, 8'h0D, 8'h0A} || v !== "H") begin
            n_errors++;
            $display("FAIL basic_response: got %h timeout=%b want 480d0a", got, to);
        end
        idle_cycles(10, seen);
        n_checks++;
        if (seen != 0 || tries_left !== 4'd6) begin
            n_errors++;
            $display("FAIL basic_after: got extra_tx=%0d tries=%0d want 0/6", seen, tries_left);
        end
    endtask

    task automatic test_win();
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        int          seen;
        model_guess("37", v);
        send_line("37", 0, 1);
        recv3(1, got, to);
        n_checks++;
        if (to || got !== {8'h43, 8'h0D, 8'h0A}) begin
            n_errors++;
            $display("FAIL win_response: got %h timeout=%b want 430d0a", got, to);
        end
        n_checks++;
        if (game_over !== 1'b1 || win !== 1'b1) begin
            n_errors++;
            $display("FAIL win_status: got over=%b win=%b want 1/1", game_over, win);
        end
        send_line("12", 0, 0);
        idle_cycles(10, seen);
        n_checks++;
        if (seen != 0 || tries_left !== 4'(m_tries)) begin
            n_errors++;
            $display("FAIL over_drop: got tx=%0d tries=%0d want 0/%0d", seen, tries_left, m_tries);
        end
        do_new_game();
        n_checks++;
        if (game_over !== 1'b0 || tries_left !== 4'd7 || secret !== 7'(m_secret)) begin
            n_errors++;
            $display("FAIL new_game_apply: got over=%b tries=%0d secret=%0d want 0/7/%0d",
                     game_over, tries_left, secret, m_secret);
        end
    endtask

    task automatic test_lose();
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        for (int k = 0; k < 20 && m_secret == 0; k++) do_new_game();
        for (int k = 0; k < MaxTries; k++) begin
            model_guess("0", v);
            send_line("0", 0, 1);
            recv3(1, got, to);
            n_checks++;
            if (to || got !== {(k == MaxTries - 1) ? 8'h58 : 8'h4C, 8'h0D, 8'h0A}) begin
                n_errors++;
                $display("FAIL lose_guess_%0d: got %h timeout=%b want verdict %h", k, got, to, v);
            end
        end
        n_checks++;
        if (tries_left !== 4'd0 || game_over !== 1'b1 || win !== 1'b0) begin
            n_errors++;
            $display("FAIL lose_status: got tries=%0d over=%b win=%b want 0/1/0",
                     tries_left, game_over, win);
        end
        do_new_game();
    endtask

    task automatic test_errors();
        string       lines [7] = '{"1a", "1234", "150", "0000", "-5", "100", "099"};
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        for (int i = 0; i < 7; i++) begin
            if (m_over) do_new_game();
            model_guess(lines[i], v);
            send_line(lines[i], $urandom_range(0, 2), 1);
            recv3(1, got, to);
            n_checks++;
            if (to || got !== {v, 8'h0D, 8'h0A} || (i < 6 && v !== "E")) begin
                n_errors++;
                $display("FAIL error_line_%0d: got %h timeout=%b want %h0d0a", i, got, to, v);
            end
            n_checks++;
            if (tries_left !== 4'(m_tries) || game_over !== 1'(m_over)) begin
                n_errors++;
                $display("FAIL error_tries_%0d: got tries=%0d over=%b want %0d/%0b",
                         i, tries_left, game_over, m_tries, m_over);
            end
        end
    endtask

    task automatic test_random();
        string       jl = "a- +x";
        string       line;
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        int          r;
        for (int it = 0; it < 40; it++) begin
            if (m_over || $urandom_range(0, 7) == 0) begin
                do_new_game();
                n_checks++;
                if (secret !== 7'(m_secret) || tries_left !== 4'(MaxTries)) begin
                    n_errors++;
                    $display("FAIL rand_new_game_%0d: got secret=%0d tries=%0d want %0d/%0d",
                             it, secret, tries_left, m_secret, MaxTries);
                end
            end
            r = $urandom_range(0, 9);
            if (r == 0) line = $sformatf("%0d%c", $urandom_range(0, 99), jl[$urandom_range(0, 4)]);
            else if (r == 1) line = $sformatf("%0d", $urandom_range(1000, 9999));
            else if (r == 2) line = $sformatf("%03d", $urandom_range(0, 99));
            else line = $sformatf("%0d", $urandom_range(0, 110));
            model_guess(line, v);
            send_line(line, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            recv3(1, got, to);
            n_checks++;
            if (to || got !== {v, 8'h0D, 8'h0A}) begin
                n_errors++;
                $display("FAIL rand_resp_%0d: line=%s got %h timeout=%b want %h0d0a",
                         it, line, got, to, v);
            end
            n_checks++;
            if (tries_left !== 4'(m_tries) || game_over !== 1'(m_over) ||
                (m_over && win !== 1'(m_win))) begin
                n_errors++;
                $display("FAIL rand_status_%0d: got tries=%0d over=%b win=%b want %0d/%0b/%0b",
                         it, tries_left, game_over, win, m_tries, m_over, m_win);
            end
        end
    endtask

    task automatic test_backpressure();
        string       line;
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        int          bad;
        int          exp_s;
        int          seen;
        if (m_over) do_new_game();
        tx_ready = 1'b0;
        line = $sformatf("%0d", $urandom_range(0, 99));
        model_guess(line, v);
        send_line(line, 0, 0);
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tx_ready = 1'b0;
            rx_valid = (i == 3) || (i == 6);
            rx_data  = (i == 3) ? 8'h35 : ((i == 6) ? 8'h0D : 8'h00);
            new_game = (i == 10) || (i == 14);
            if (tx_valid !== 1'b1 || tx_data !== v) bad++;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; new_game = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0 (verdict %h)", bad, v);
        end
        recv3(0, got, to);
        n_checks++;
        if (to || got !== {v, 8'h0D, 8'h0A}) begin
            n_errors++;
            $display("FAIL stall_response: got %h timeout=%b want %h0d0a", got, to, v);
        end
        exp_s = ref_reduce(m_lfsr);
        @(posedge clk); #1;
        m_secret = exp_s; m_tries = MaxTries; m_over = 0; m_win = 0;
        n_checks++;
        if (secret !== 7'(m_secret) || tries_left !== 4'd7 || game_over !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_new_game: got secret=%0d tries=%0d over=%b want %0d/7/0",
                     secret, tries_left, game_over, m_secret);
        end
        idle_cycles(10, seen);
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL stall_rx_dropped: got %0d tx cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid_send();
        logic [7:0]  v;
        logic [23:0] got;
        bit          to;
        tx_ready = 1'b1;
        send_line("50", 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h0D) begin
            n_errors++;
            $display("FAIL midsend_second_byte: got valid=%b data=%h want 1/0d", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midsend_async_drop: got tx_valid=%b want 0", tx_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        m_secret = ref_reduce(Seed); m_tries = MaxTries; m_over = 0; m_win = 0;
        n_checks++;
        if (tx_data !== 8'h00 || tries_left !== 4'd7 || game_over !== 1'b0 || win !== 1'b0 ||
            secret !== 7'd37) begin
            n_errors++;
            $display("FAIL midsend_reset_vals: got data=%h tries=%0d over=%b win=%b secret=%0d want 00/7/0/0/37",
                     tx_data, tries_left, game_over, win, secret);
        end
        model_guess("50", v);
        send_line("50", 0, 1);
        recv3(1, got, to);
        n_checks++;
        if (to || got !== {8'h48, 8'h0D, 8'h0A} || tries_left !== 4'd6) begin
            n_errors++;
            $display("FAIL midsend_resume: got %h timeout=%b tries=%0d want 480d0a/6", got, to, tries_left);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached want finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_win();
        test_lose();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
